// File: rtl/micro_inport_edge_pkg.sv
// Shared definitions for the edge-capture input peripheral: register word addresses.
package micro_inport_edge_pkg;

  localparam logic [3:0] ADDR_DATA = 4'd0;
  localparam logic [3:0] ADDR_RISE = 4'd1;
  localparam logic [3:0] ADDR_FALL = 4'd2;
  localparam logic [3:0] ADDR_PEND = 4'd3;
  localparam logic [3:0] ADDR_MASK = 4'd4;
  localparam logic [3:0] ADDR_DEB  = 4'd5;

endpackage

// File: rtl/micro_inport_edge_if.sv
// Peripheral bus bundle for the forth_micro bus: CPU side is master, peripheral is slave.
interface micro_inport_edge_if #(
  parameter int WIDTHD = 1
);

  logic [3:0]        address;
  logic [WIDTHD-1:0] writedata;
  logic [WIDTHD-1:0] readdata;
  logic              read;
  logic              write;
  logic              waitrequest;

  modport master (
    output address, writedata, read, write,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, writedata, read, write,
    output readdata, waitrequest
  );

endinterface

// File: rtl/micro_debounce_bit.sv
// One-bit debouncer: the output follows the synchronised input only after it has
// differed for thresh+1 consecutive cycles. update pulses in the cycle the output flips.
module micro_debounce_bit
  import micro_inport_edge_pkg::*;
#(
  parameter int DEBW = 8
) (
  input  logic            clock,
  input  logic            clock_sreset,
  input  logic            in,
  input  logic [DEBW-1:0] thresh,
  output logic            out,
  output logic            update
);

  logic [DEBW-1:0] r_cnt;
  logic            r_deb;
  logic            w_differ;
  logic            w_expire;

  assign w_differ = in ^ r_deb;
  // >= rather than == so that lowering the threshold mid-count never lets the counter wrap
  assign w_expire = w_differ && (r_cnt >= thresh);
  assign update   = w_expire;
  assign out      = r_deb;

  // Count consecutive differing cycles; accept the new level when the count reaches thresh.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (!w_differ) begin
      r_cnt <= '0;
    end else if (w_expire) begin
      r_deb <= in;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/micro_inport_edge.sv
// Edge-capture input port: synchronises and debounces each input bit, latches enabled
// rise/fall events into a write-one-to-clear pending register and raises a maskable irq.
// Reads take two cycles (one wait state); writes complete with no wait state.
module micro_inport_edge
  import micro_inport_edge_pkg::*;
#(
  parameter int WIDTHD = 1,
  parameter int DEBW   = 8
) (
  input  logic              clock,
  input  logic              clock_sreset,
  micro_inport_edge_if.slave bus,
  input  logic [WIDTHD-1:0] inport,
  output logic              irq
);

  logic [WIDTHD-1:0] r_s0, r_s1, r_s2;
  logic [WIDTHD-1:0] r_rise, r_fall, r_pend, r_mask;
  logic [DEBW-1:0]   r_thresh;
  logic [WIDTHD-1:0] r_readdata;
  logic              r_read_latency;

  logic [WIDTHD-1:0] w_deb;
  logic [WIDTHD-1:0] w_update;
  logic [WIDTHD-1:0] w_set;
  logic [WIDTHD-1:0] w_w1c;
  logic [WIDTHD-1:0] w_rdata;
  logic              w_rd_first;

  // Three-flop synchroniser per bit; deliberately not reset.
  always_ff @(posedge clock) begin
    r_s0 <= inport;
    r_s1 <= r_s0;
    r_s2 <= r_s1;
  end

  for (genvar gi = 0; gi < WIDTHD; gi++) begin : g_deb
    micro_debounce_bit #(.DEBW(DEBW)) u_deb (
      .clock        (clock),
      .clock_sreset (clock_sreset),
      .in           (r_s2[gi]),
      .thresh       (r_thresh),
      .out          (w_deb[gi]),
      .update       (w_update[gi])
    );
  end

  // A debounced transition is an event when it matches the enabled edge direction.
  assign w_set = w_update & ((r_s2 & r_rise) | (~r_s2 & r_fall));
  assign w_w1c = (bus.write && (bus.address == ADDR_PEND)) ? bus.writedata : '0;

  // Control registers and pending latch; a new event beats a same-cycle clear.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_rise   <= '0;
      r_fall   <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_thresh <= '0;
    end else begin
      if (bus.write) begin
        case (bus.address)
          ADDR_RISE: r_rise   <= bus.writedata;
          ADDR_FALL: r_fall   <= bus.writedata;
          ADDR_MASK: r_mask   <= bus.writedata;
          ADDR_DEB:  r_thresh <= DEBW'(bus.writedata);
          default:   ;
        endcase
      end
      r_pend <= (r_pend & ~w_w1c) | w_set;
    end
  end

  // Read data select; unmapped addresses return zero.
  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA: w_rdata = w_deb;
      ADDR_RISE: w_rdata = r_rise;
      ADDR_FALL: w_rdata = r_fall;
      ADDR_PEND: w_rdata = r_pend;
      ADDR_MASK: w_rdata = r_mask;
      ADDR_DEB:  w_rdata = WIDTHD'(r_thresh);
      default:   w_rdata = '0;
    endcase
  end

  // First cycle of a read stalls the bus; a simultaneous write takes priority.
  assign w_rd_first      = bus.read && !bus.write && !r_read_latency;
  assign bus.waitrequest = w_rd_first;
  assign bus.readdata    = r_readdata;

  // Capture read data in the stall cycle; the latency flag lasts exactly one cycle.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_read_latency <= 1'b0;
      r_readdata     <= '0;
    end else begin
      r_read_latency <= w_rd_first;
      if (w_rd_first) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign irq = |(r_pend & r_mask);

endmodule

// File: tb/tb_micro_inport_edge.sv
// Bench for micro_inport_edge (8-bit port): directed scenarios plus a randomized phase,
// all compared against a cycle-level behavioural model of the peripheral.
module tb_micro_inport_edge;

  logic       clk;
  logic       rst;
  logic [7:0] inport;
  logic       irq;

  int n_total;
  int n_bad;

  micro_inport_edge_if #(.WIDTHD(8)) bus_if ();

  micro_inport_edge #(.WIDTHD(8), .DEBW(8)) dut (
    .clock        (clk),
    .clock_sreset (rst),
    .bus          (bus_if),
    .inport       (inport),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_q[$];
  logic [7:0] m_deb, m_rise, m_fall, m_pend, m_mask;
  int         m_thr;
  int         m_streak[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_irq();
    return |(m_pend & m_mask);
  endfunction

  function automatic logic [7:0] m_reg(input logic [3:0] a);
    case (a)
      4'd0:    return m_deb;
      4'd1:    return m_rise;
      4'd2:    return m_fall;
      4'd3:    return m_pend;
      4'd4:    return m_mask;
      4'd5:    return 8'(m_thr);
      default: return 8'h00;
    endcase
  endfunction

  // Advance the model by one clock edge given the inputs present at that edge.
  task automatic model_step(input logic [7:0] inp, input logic rs, input logic wr,
                            input logic [3:0] addr, input logic [7:0] wd);
    logic [7:0] s2, upd, w1c, nxt, evt;
    s2 = m_q.pop_front();
    m_q.push_back(inp);
    if (rs) begin
      m_deb = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_mask = 0; m_thr = 0;
      for (int b = 0; b < 8; b++) m_streak[b] = 0;
    end else begin
      upd = 8'h00;
      w1c = 8'h00;
      nxt = m_deb;
      for (int b = 0; b < 8; b++) begin
        if (s2[b] != m_deb[b]) begin
          m_streak[b]++;
          if (m_streak[b] > m_thr) begin
            nxt[b] = s2[b];
            upd[b] = 1'b1;
            m_streak[b] = 0;
          end
        end else begin
          m_streak[b] = 0;
        end
      end
      evt = upd & ((s2 & m_rise) | (~s2 & m_fall));
      if (wr) begin
        case (addr)
          4'd1: m_rise = wd;
          4'd2: m_fall = wd;
          4'd3: w1c = wd;
          4'd4: m_mask = wd;
          4'd5: m_thr = int'(wd);
          default: ;
        endcase
      end
      m_pend = (m_pend & ~w1c) | evt;
      m_deb = nxt;
    end
  endtask

  task automatic tick();
    logic [7:0] c_inp, c_wd;
    logic       c_rst, c_wr;
    logic [3:0] c_addr;
    c_inp  = inport;
    c_rst  = rst;
    c_wr   = bus_if.write;
    c_addr = bus_if.address;
    c_wd   = bus_if.writedata;
    @(posedge clk);
    #1;
    model_step(c_inp, c_rst, c_wr, c_addr, c_wd);
    chk("irq", {31'd0, irq}, {31'd0, m_irq()});
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bus_if.address   = a;
    bus_if.writedata = d;
    bus_if.write     = 1'b1;
    tick();
    bus_if.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input string tag, output logic [7:0] rd);
    logic [7:0] exp;
    bus_if.address = a;
    bus_if.read    = 1'b1;
    #1;
    chk({tag, "_wait1"}, {31'd0, bus_if.waitrequest}, 32'd1);
    exp = m_reg(a);
    tick();
    chk({tag, "_wait0"}, {31'd0, bus_if.waitrequest}, 32'd0);
    chk(tag, {24'd0, bus_if.readdata}, {24'd0, exp});
    rd = bus_if.readdata;
    tick();
    bus_if.read = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    int         acc;
    int         op;
    logic [3:0] ra;
    logic [7:0] rv;

    n_total = 0;
    n_bad   = 0;
    m_q     = '{8'h00, 8'h00, 8'h00};
    m_deb = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_mask = 0; m_thr = 0;
    for (int b = 0; b < 8; b++) m_streak[b] = 0;

    rst              = 1'b1;
    inport           = 8'h00;
    bus_if.address   = 4'd0;
    bus_if.writedata = 8'h00;
    bus_if.read      = 1'b0;
    bus_if.write     = 1'b0;

    // T1 reset
    tick();
    tick();
    rst = 1'b0;
    chk("t1_readdata", {24'd0, bus_if.readdata}, 32'd0);
    chk("t1_irq", {31'd0, irq}, 32'd0);
    chk("t1_wait", {31'd0, bus_if.waitrequest}, 32'd0);
    for (int a = 0; a < 6; a++) begin
      bus_read(4'(a), "t1_reg", rd);
      chk("t1_reg_zero", {24'd0, rd}, 32'd0);
    end

    // T2 back-to-back read timing
    bus_write(4'd1, 8'hA5);
    acc = 0;
    bus_if.address = 4'd1;
    bus_if.read    = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t2_wait", {31'd0, bus_if.waitrequest}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (!bus_if.waitrequest) begin
        acc++;
        chk("t2_data", {24'd0, bus_if.readdata}, 32'hA5);
      end
      tick();
    end
    bus_if.read = 1'b0;
    chk("t2_accepts", acc, 3);

    // T3 rise event and irq latency, DEB=0
    bus_write(4'd5, 8'h00);
    bus_write(4'd1, 8'h01);
    bus_write(4'd2, 8'h00);
    bus_write(4'd4, 8'h01);
    inport = 8'h01;
    tick(); tick(); tick();
    chk("t3_irq_n2", {31'd0, irq}, 32'd0);
    tick();
    chk("t3_irq_n3", {31'd0, irq}, 32'd1);
    bus_read(4'd3, "t3_pend", rd);
    chk("t3_pend_val", {24'd0, rd}, 32'h01);
    bus_write(4'd3, 8'h01);
    chk("t3_irq_clr", {31'd0, irq}, 32'd0);

    // T4 debounce, DEB=4
    bus_write(4'd4, 8'h02);
    bus_write(4'd1, 8'h02);
    bus_write(4'd2, 8'h00);
    bus_write(4'd5, 8'h04);
    inport = 8'h03;
    repeat (3) tick();
    inport = 8'h01;
    repeat (10) tick();
    chk("t4_glitch_irq", {31'd0, irq}, 32'd0);
    bus_read(4'd0, "t4_data_glitch", rd);
    chk("t4_data_glitch_val", {24'd0, rd}, 32'h01);
    bus_read(4'd3, "t4_pend_glitch", rd);
    chk("t4_pend_glitch_val", {24'd0, rd}, 32'h00);
    inport = 8'h03;
    repeat (7) tick();
    chk("t4_irq_early", {31'd0, irq}, 32'd0);
    tick();
    chk("t4_irq", {31'd0, irq}, 32'd1);
    bus_read(4'd0, "t4_data", rd);
    chk("t4_data_val", {24'd0, rd}, 32'h03);

    // T5 set beats same-cycle W1C
    bus_write(4'd3, 8'h02);
    bus_write(4'd2, 8'h01);
    bus_write(4'd5, 8'h00);
    bus_write(4'd4, 8'h01);
    inport = 8'h02;
    repeat (3) tick();
    bus_write(4'd3, 8'h01);
    chk("t5_irq", {31'd0, irq}, 32'd1);
    bus_read(4'd3, "t5_pend", rd);
    chk("t5_pend_val", {24'd0, rd}, 32'h01);

    // T6 mask and unmapped address
    bus_write(4'd3, 8'h01);
    bus_write(4'd1, 8'h02);
    inport = 8'h00;
    repeat (5) tick();
    inport = 8'h02;
    repeat (5) tick();
    bus_write(4'd4, 8'h01);
    chk("t6_masked", {31'd0, irq}, 32'd0);
    bus_write(4'd4, 8'h03);
    chk("t6_unmasked", {31'd0, irq}, 32'd1);
    bus_read(4'd9, "t6_rd9", rd);
    chk("t6_rd9_val", {24'd0, rd}, 32'h00);
    bus_write(4'd9, 8'hFF);
    for (int a = 1; a < 6; a++) bus_read(4'(a), "t6_after_wr9", rd);
    bus_read(4'd4, "t6_mask", rd);
    chk("t6_mask_val", {24'd0, rd}, 32'h03);
    bus_read(4'd3, "t6_pend", rd);
    chk("t6_pend_val", {24'd0, rd}, 32'h02);

    // Reset in the middle of a read restarts the handshake
    bus_if.address = 4'd1;
    bus_if.read    = 1'b1;
    tick();
    chk("rst_rd_wait0", {31'd0, bus_if.waitrequest}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rd_restart", {31'd0, bus_if.waitrequest}, 32'd1);
    tick();
    chk("rst_rd_wait", {31'd0, bus_if.waitrequest}, 32'd0);
    chk("rst_rd_data", {24'd0, bus_if.readdata}, {24'd0, m_reg(4'd1)});
    tick();
    bus_if.read = 1'b0;

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 2) == 0) inport = inport ^ 8'(1 << $urandom_range(0, 7));
      op = $urandom_range(0, 9);
      if (op < 4) begin
        tick();
      end else if (op < 7) begin
        ra = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 5));
        rv = (ra == 4'd5) ? 8'($urandom_range(0, 6)) : 8'($urandom);
        bus_write(ra, rv);
      end else begin
        ra = 4'($urandom_range(0, 7));
        bus_read(ra, "rnd_read", rd);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
